// File: rtl/cu_cache_command_responder.sv
// Responder side of the CU cache command interface: accepts READ/WRITE requests, drives a
// fixed-latency word SRAM and returns in-order responses through a small credit-limited FIFO.
module cu_cache_command_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 8,
  parameter int MEM_ADDR_W = 10,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W/8-1:0]     req_wstrb,
  input  logic [ID_W-1:0]         req_id,
  output logic                    mem_en,
  output logic [DATA_W/8-1:0]     mem_we,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_rdata,
  input  logic                    drain_req,
  output logic                    drain_done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BYTE_W = $clog2(NBYTES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic              drain_done_q;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              req_fire, rsp_fire;

  logic [RD_LATENCY-1:0]           pv_q;
  logic [RD_LATENCY-1:0]           pw_q;
  logic [RD_LATENCY-1:0][ID_W-1:0] pid_q;

  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]  wr_idx, rd_idx;
  logic              fifo_empty, push_en;
  logic              fifo_write_q [FIFO_DEPTH];
  logic [ID_W-1:0]   fifo_id_q    [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_rdata_q [FIFO_DEPTH];

  logic              unused_addr;

  // Credit check uses only registered state so req_ready never depends on inputs.
  assign req_ready = (state_q == ST_READY) && (inflight_q < CNT_W'(FIFO_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  assign mem_en    = req_fire;
  assign mem_we    = (req_fire && req_write) ? req_wstrb : '0;
  assign mem_addr  = req_fire ? req_addr[BYTE_W +: MEM_ADDR_W] : '0;
  assign mem_wdata = req_fire ? req_wdata : '0;
  assign unused_addr = ^req_addr;

  assign drain_done = drain_done_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= ST_RESET;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_READY;
        ST_READY: if (drain_req) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (inflight_q == '0) begin
            state_q      <= ST_DONE;
            drain_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            state_q      <= ST_READY;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RESET;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire && !rsp_fire) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!req_fire && rsp_fire) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // Tags for reads and writes travel together so the FIFO sees them in acceptance order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pv_q  <= '0;
      pw_q  <= '0;
      pid_q <= '0;
    end else begin
      pv_q[0]  <= req_fire;
      pw_q[0]  <= req_write;
      pid_q[0] <= req_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pw_q[i]  <= pw_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  assign push_en    = pv_q[RD_LATENCY-1];
  assign wr_idx     = wr_ptr_q[PTR_W-1:0];
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rsp_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked by rsp_valid and pointers gate visibility.
  always_ff @(posedge ap_clk) begin
    if (push_en) begin
      fifo_write_q[wr_idx] <= pw_q[RD_LATENCY-1];
      fifo_id_q[wr_idx]    <= pid_q[RD_LATENCY-1];
      fifo_rdata_q[wr_idx] <= pw_q[RD_LATENCY-1] ? '0 : mem_rdata;
    end
  end

  assign rsp_valid = !fifo_empty;
  assign rsp_write = rsp_valid ? fifo_write_q[rd_idx] : 1'b0;
  assign rsp_id    = rsp_valid ? fifo_id_q[rd_idx] : '0;
  assign rsp_rdata = rsp_valid ? fifo_rdata_q[rd_idx] : '0;

endmodule

// File: tb/tb_cu_cache_command_responder.sv
// Bench for cu_cache_command_responder: SRAM model, word-array reference memory and an
// expected-response queue checked by an independent monitor.
module tb_cu_cache_command_responder;

  localparam int LAT = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [7:0]  req_id;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [7:0]  rsp_id;
  logic [31:0] rsp_rdata;
  logic        drain_req, drain_done;

  cu_cache_command_responder #(
    .ADDR_W(32), .DATA_W(32), .ID_W(8), .MEM_ADDR_W(10), .RD_LATENCY(LAT), .FIFO_DEPTH(4)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_id(req_id),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .drain_req(drain_req), .drain_done(drain_done)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic        w;
    logic [7:0]  id;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          stall_cnt = 0;
  bit          rand_rdy = 1'b0;
  logic [31:0] ref_mem [1024];
  logic [31:0] sram    [1024];
  logic [31:0] rd_pipe [LAT];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Word SRAM with LAT-cycle read latency.
  always @(posedge ap_clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      rd_pipe[0] <= sram[mem_addr];
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge ap_clk) begin
    if (rand_rdy) begin
      #1;
      rsp_ready = ($urandom_range(3) != 0);
    end
  end

  // Monitor: pops expected responses and checks that a stalled response holds steady.
  logic        prev_stall = 1'b0;
  logic [40:0] prev_rsp;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("rsp_hold", {23'd0, rsp_valid, rsp_write, rsp_id, rsp_rdata},
                            {23'd0, 1'b1, prev_rsp});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got id=%0h want none", rsp_id);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_write", 64'(rsp_write), 64'(e.w));
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
          $display("rsp id=%0h write=%0b rdata=%08h", rsp_id, rsp_write, rsp_rdata);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp   = {rsp_write, rsp_id, rsp_rdata};
    end
  end

  // Call just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [7:0] id);
    bit acc;
    int n;
    int idx;
    acc = 1'b0;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_id = id;
    while (!acc) begin
      @(negedge ap_clk);
      acc = req_ready;
      @(posedge ap_clk);
      #1;
      if (acc) begin
        idx = int'((a >> 2) & 32'h3FF);
        if (w) begin
          for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
          end
          exp_q.push_back('{w: 1'b1, id: id, rd: 32'd0});
        end else begin
          exp_q.push_back('{w: 1'b0, id: id, rd: ref_mem[idx]});
        end
      end else begin
        n++;
        stall_cnt++;
        if (n > 200) begin
          total++;
          bad++;
          $display("FAIL req_timeout: id=%0h not accepted, want accept within 200 cycles", id);
          acc = 1'b1;
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit stale;
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'd0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; req_id = 0;
    rsp_ready = 0; drain_req = 0;

    repeat (3) @(posedge ap_clk);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_drain_done", 64'(drain_done), 64'd0);
    check("reset_mem_en", 64'(mem_en), 64'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Write then latency check: ack visible exactly three cycles after the accept cycle.
    rsp_ready = 1'b1;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 8'd3);
    check("lat_t1", 64'(rsp_valid), 64'd0);
    @(posedge ap_clk); #1;
    check("lat_t2", 64'(rsp_valid), 64'd0);
    @(posedge ap_clk); #1;
    check("lat_t3", 64'(rsp_valid), 64'd1);

    send(1'b0, 32'h10, 32'h0, 4'h0, 8'd4);
    send(1'b1, 32'h10, 32'h55, 4'h1, 8'd5);
    send(1'b0, 32'h10, 32'h0, 4'h0, 8'd6);
    send(1'b1, 32'h10, 32'h12345678, 4'h0, 8'd7);
    send(1'b0, 32'h10, 32'h0, 4'h0, 8'd8);
    send(1'b0, 32'hABC0_0012, 32'h0, 4'h0, 8'd9);
    wait_idle("idle_directed");

    // Credit limit: four accepted with responses blocked, then release.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 32'h10 + 32'(4 * i), 32'h0, 4'h0, 8'(10 + i));
    repeat (3) @(posedge ap_clk);
    #1;
    check("credit_full_ready", 64'(req_ready), 64'd0);
    check("credit_full_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    send(1'b0, 32'h14, 32'h0, 4'h0, 8'd14);
    send(1'b0, 32'h18, 32'h0, 4'h0, 8'd15);
    wait_idle("idle_credit");

    // Full FIFO then simultaneous pop and accept: one stall only, then full rate.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 32'(4 * i), 32'(i * 32'h1111), 4'hF, 8'(20 + i));
    repeat (4) @(posedge ap_clk);
    #1;
    stall_cnt = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(1'b0, 32'(4 * (i % 6)), 32'h0, 4'h0, 8'(30 + i));
    check("steady_stalls", 64'(stall_cnt), 64'd1);
    wait_idle("idle_steady");

    // Drain with three reads outstanding.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 32'(4 * i), 32'h0, 4'h0, 8'(60 + i));
    drain_req = 1'b1;
    @(posedge ap_clk); #1;
    check("drain_ready_low", 64'(req_ready), 64'd0);
    check("drain_not_done", 64'(drain_done), 64'd0);
    rsp_ready = 1'b1;
    for (int n = 0; n < 50 && !drain_done; n++) begin
      @(posedge ap_clk); #1;
    end
    check("drain_done", 64'(drain_done), 64'd1);
    check("drain_all_popped", 64'(exp_q.size()), 64'd0);
    check("done_ready_low", 64'(req_ready), 64'd0);
    drain_req = 1'b0;
    @(posedge ap_clk); #1;
    check("undrain_ready", 64'(req_ready), 64'd1);
    check("undrain_done_low", 64'(drain_done), 64'd0);

    // Asynchronous reset with requests in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 32'(4 * i), 32'h0, 4'h0, 8'(70 + i));
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rst_release_wait", 64'(req_ready), 64'd0);
    @(posedge ap_clk); #1;
    check("rst_release_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(posedge ap_clk); #1;
      if (rsp_valid) stale = 1'b1;
    end
    check("no_stale_rsp", 64'(stale), 64'd0);

    // Randomized traffic with random back-pressure and aliased upper address bits.
    rand_rdy = 1'b1;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      repeat ($urandom_range(2)) begin
        @(posedge ap_clk); #1;
      end
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
      send(1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)), 8'($urandom_range(255)));
    end
    @(posedge ap_clk);
    rand_rdy = 1'b0;
    #2;
    rsp_ready = 1'b1;
    wait_idle("idle_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
